// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational MIPS ALU between two requesters,
// with a one-deep registered response slot and saturating per-requester grant counters.

module alu (
    input  logic [31:0] instruction,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    output logic [31:0] result,
    output logic [2:0]  flags
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] res;
    logic        ovf;
    logic        unused_fields;

    assign opcode        = instruction[31:26];
    assign funct         = instruction[5:0];
    assign shamt         = instruction[10:6];
    assign imm_s         = {{16{instruction[15]}}, instruction[15:0]};
    assign imm_z         = {16'b0, instruction[15:0]};
    assign unused_fields = ^instruction[25:16];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: res = regB << shamt;
                    6'h02: res = regB >> shamt;
                    6'h03: res = $signed(regB) >>> shamt;
                    6'h04: res = regB << regA[4:0];
                    6'h06: res = regB >> regA[4:0];
                    6'h07: res = $signed(regB) >>> regA[4:0];
                    6'h20: begin
                        res = regA + regB;
                        ovf = (regA[31] == regB[31]) && (res[31] != regA[31]);
                    end
                    6'h21: res = regA + regB;
                    6'h22: begin
                        res = regA - regB;
                        ovf = (regA[31] != regB[31]) && (res[31] != regA[31]);
                    end
                    6'h23: res = regA - regB;
                    6'h24: res = regA & regB;
                    6'h25: res = regA | regB;
                    6'h26: res = regA ^ regB;
                    6'h27: res = ~(regA | regB);
                    6'h2A: res = {31'b0, $signed(regA) < $signed(regB)};
                    6'h2B: res = {31'b0, regA < regB};
                    default: res = '0;
                endcase
            end
            // Branch compares subtract so the zero flag carries the equality outcome.
            6'h04, 6'h05: res = regA - regB;
            6'h08: begin
                res = regA + imm_s;
                ovf = (regA[31] == imm_s[31]) && (res[31] != regA[31]);
            end
            6'h09: res = regA + imm_s;
            6'h0A: res = {31'b0, $signed(regA) < $signed(imm_s)};
            6'h0B: res = {31'b0, regA < imm_s};
            6'h0C: res = regA & imm_z;
            6'h0D: res = regA | imm_z;
            6'h0E: res = regA ^ imm_z;
            6'h0F: res = {instruction[15:0], 16'b0};
            default: res = '0;
        endcase
    end

    assign result = res;
    assign flags  = {res == 32'b0, res[31], ovf};
endmodule

module alu_arb_gnt_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module alu_arbiter #(
    parameter int PRIO_INIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_instr,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_instr,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic             busy
);
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef enum logic {S_IDLE, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic        prio_q, prio_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

    alu_req_t [NUM_REQ-1:0]            req;
    logic     [NUM_REQ-1:0]            grant;
    logic     [NUM_REQ-1:0][CNT_W-1:0] cnt;
    alu_req_t                          sel;
    logic                              own_rdy, slot_free, any_vld, win_sel, accept;
    logic     [31:0]                   alu_result;
    logic     [2:0]                    alu_flags;

    assign req[0] = '{instr: req0_instr, a: req0_a, b: req0_b};
    assign req[1] = '{instr: req1_instr, a: req1_a, b: req1_b};

    // Slot frees in the same cycle the owner drains it, giving 1 op/cycle streaming.
    assign own_rdy   = own_q ? rsp1_ready : rsp0_ready;
    assign slot_free = (state_q == S_IDLE) || own_rdy;
    assign any_vld   = req0_valid || req1_valid;
    assign win_sel   = req1_valid && (!req0_valid || prio_q);
    assign accept    = slot_free && any_vld;

    assign req0_ready = slot_free && req0_valid && !win_sel;
    assign req1_ready = slot_free && win_sel;

    assign sel = req[win_sel];

    alu u_alu (
        .instruction (sel.instr),
        .regA        (sel.a),
        .regB        (sel.b),
        .result      (alu_result),
        .flags       (alu_flags)
    );

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        prio_d   = prio_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (accept) begin
            state_d  = S_HOLD;
            own_d    = win_sel;
            prio_d   = ~win_sel;
            result_d = alu_result;
            flags_d  = alu_flags;
        end else if ((state_q == S_HOLD) && own_rdy) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            own_q    <= 1'b0;
            prio_q   <= 1'(PRIO_INIT);
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            prio_q   <= prio_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant[g] = accept && (win_sel == 1'(g));
        alu_arb_gnt_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (grant[g]),
            .cnt_o (cnt[g])
        );
    end

    assign rsp0_valid = (state_q == S_HOLD) && !own_q;
    assign rsp1_valid = (state_q == S_HOLD) && own_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign gnt_cnt0   = cnt[0];
    assign gnt_cnt1   = cnt[1];
    assign busy       = (state_q == S_HOLD);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, grant order, streaming, backpressure,
// asynchronous reset while holding, fairness and counter saturation.

module tb_alu_arbiter;
    localparam logic [31:0] I_ADD = 32'h00221820;
    localparam logic [31:0] I_SUB = 32'h00221822;
    localparam logic [31:0] I_BEQ = 32'h10208020;

    logic        clk, rst_n;
    logic        r0v, r1v, s0r, s1r;
    logic [31:0] r0i, r0a, r0b, r1i, r1a, r1b;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    logic        s_r1v, s_s1r;
    logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_busy;
    logic [31:0] s_result;
    logic [2:0]  s_flags;
    logic [1:0]  s_cnt0, s_cnt1;

    int errs = 0;
    int checks = 0;

    alu_arbiter #(.PRIO_INIT(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_instr(r0i), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_instr(r1i), .req1_a(r1a), .req1_b(r1b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(s0r), .rsp1_valid(rsp1_valid), .rsp1_ready(s1r),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .busy(busy)
    );

    alu_arbiter #(.PRIO_INIT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(1'b0), .req0_ready(s_req0_ready), .req0_instr(32'h0), .req0_a(32'h0), .req0_b(32'h0),
        .req1_valid(s_r1v), .req1_ready(s_req1_ready), .req1_instr(I_ADD), .req1_a(32'd1), .req1_b(32'd1),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(1'b0), .rsp1_valid(s_rsp1_valid), .rsp1_ready(s_s1r),
        .rsp_result(s_result), .rsp_flags(s_flags),
        .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0;
        r0v = 0; r1v = 0; s0r = 0; s1r = 0; s_r1v = 0; s_s1r = 0;
        r0i = 0; r0a = 0; r0b = 0; r1i = 0; r1a = 0; r1b = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errs++;
            $display("FAIL reset_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp_result !== 32'd0 || rsp_flags !== 3'd0) begin errs++;
            $display("FAIL reset_data: got %h/%b want 0/000", rsp_result, rsp_flags); end
        checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0 || busy !== 1'b0) begin errs++;
            $display("FAIL reset_cnt_busy: got %0d %0d %b want 0 0 0", gnt_cnt0, gnt_cnt1, busy); end
    endtask

    task automatic test_add;
        @(negedge clk);
        r0v = 1; r0i = I_ADD; r0a = 3; r0b = 2;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errs++;
            $display("FAIL add_ready: got %b%b want 01", req1_ready, req0_ready); end
        @(posedge clk); #1;
        r0v = 0;
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || busy !== 1'b1) begin errs++;
            $display("FAIL add_rsp_valid: got %b%b busy %b want 01 busy 1", rsp1_valid, rsp0_valid, busy); end
        checks++; if (rsp_result !== 32'd5 || rsp_flags !== 3'b000) begin errs++;
            $display("FAIL add_data: got %0d/%b want 5/000", rsp_result, rsp_flags); end
        checks++; if (gnt_cnt0 !== 16'd1) begin errs++;
            $display("FAIL add_cnt0: got %0d want 1", gnt_cnt0); end
        @(negedge clk); s0r = 1;
        @(posedge clk); #1; s0r = 0;
        checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errs++;
            $display("FAIL add_drain: got busy %b rsp0 %b want 0 0", busy, rsp0_valid); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        @(negedge clk);
        r0v = 1; r0i = I_SUB; r0a = 3; r0b = 2;
        r1v = 1; r1i = I_BEQ; r1a = 2; r1b = 2;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errs++;
            $display("FAIL sim_first_grant: got %b%b want 01", req1_ready, req0_ready); end
        @(posedge clk); #1;
        r0v = 0;
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_flags !== 3'b000) begin errs++;
            $display("FAIL sim_sub: got v%b %0d/%b want v1 1/000", rsp0_valid, rsp_result, rsp_flags); end
        checks++; if (req1_ready !== 1'b0) begin errs++;
            $display("FAIL sim_req1_blocked: got %b want 0", req1_ready); end
        @(negedge clk); s0r = 1; #1;
        checks++; if (req1_ready !== 1'b1) begin errs++;
            $display("FAIL sim_req1_grant: got %b want 1", req1_ready); end
        @(posedge clk); #1;
        s0r = 0; r1v = 0;
        checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_flags !== 3'b100 || rsp_result !== 32'd0) begin errs++;
            $display("FAIL sim_beq: got v%b%b %0d/%b want v10 0/100", rsp1_valid, rsp0_valid, rsp_result, rsp_flags); end
        checks++; if (gnt_cnt0 !== 16'd1 || gnt_cnt1 !== 16'd1) begin errs++;
            $display("FAIL sim_cnts: got %0d %0d want 1 1", gnt_cnt0, gnt_cnt1); end
        @(negedge clk); s1r = 1;
        @(posedge clk); #1; s1r = 0;
        checks++; if (busy !== 1'b0) begin errs++;
            $display("FAIL sim_drain: got busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        s0r = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0v = 1; r0i = I_ADD; r0a = 32'(i + 1); r0b = 10;
            #1;
            checks++; if (req0_ready !== 1'b1) begin errs++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, req0_ready); end
            @(posedge clk); #1;
            checks++; if (rsp0_valid !== 1'b1 || busy !== 1'b1 || rsp_result !== 32'(i + 11)) begin errs++;
                $display("FAIL b2b_rsp[%0d]: got v%b busy %b res %0d want v1 busy 1 res %0d",
                         i, rsp0_valid, busy, rsp_result, i + 11); end
        end
        @(negedge clk); r0v = 0;
        @(posedge clk); #1; s0r = 0;
        checks++; if (gnt_cnt0 !== 16'd4 || busy !== 1'b0) begin errs++;
            $display("FAIL b2b_end: got cnt %0d busy %b want 4 0", gnt_cnt0, busy); end
    endtask

    task automatic test_backpressure;
        do_reset();
        @(negedge clk);
        r1v = 1; r1i = I_ADD; r1a = 7; r1b = 8;
        @(posedge clk); #1;
        r1v = 0;
        r0v = 1; r0i = I_SUB; r0a = 9; r0b = 4;
        s0r = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (req0_ready !== 1'b0) begin errs++;
                $display("FAIL bp_req0_ready[%0d]: got %b want 0", i, req0_ready); end
            @(posedge clk); #1;
            checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 32'd15 || rsp_flags !== 3'b000) begin errs++;
                $display("FAIL bp_hold[%0d]: got v%b%b %0d/%b want v10 15/000",
                         i, rsp1_valid, rsp0_valid, rsp_result, rsp_flags); end
        end
        @(negedge clk); s1r = 1; #1;
        checks++; if (req0_ready !== 1'b1) begin errs++;
            $display("FAIL bp_release_ready: got %b want 1", req0_ready); end
        @(posedge clk); #1;
        s1r = 0; r0v = 0;
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd5) begin errs++;
            $display("FAIL bp_req0_rsp: got v%b%b %0d want v01 5", rsp1_valid, rsp0_valid, rsp_result); end
        checks++; if (gnt_cnt0 !== 16'd1 || gnt_cnt1 !== 16'd1) begin errs++;
            $display("FAIL bp_cnts: got %0d %0d want 1 1", gnt_cnt0, gnt_cnt1); end
        @(posedge clk); #1; s0r = 0;
        checks++; if (busy !== 1'b0) begin errs++;
            $display("FAIL bp_drain: got busy %b want 0", busy); end
    endtask

    task automatic test_fairness;
        do_reset();
        @(negedge clk);
        r0v = 1; r0i = I_ADD; r0a = 3;  r0b = 2;
        r1v = 1; r1i = I_ADD; r1a = 20; r1b = 1;
        s0r = 1; s1r = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (rsp0_valid !== ((k % 2) == 0) || rsp1_valid !== ((k % 2) == 1)
                          || rsp_result !== (((k % 2) == 0) ? 32'd5 : 32'd21)) begin errs++;
                $display("FAIL fair[%0d]: got v%b%b res %0d want owner %0d", k, rsp1_valid, rsp0_valid,
                         rsp_result, k % 2); end
        end
        @(negedge clk); r0v = 0; r1v = 0;
        @(posedge clk); #1; s0r = 0; s1r = 0;
        checks++; if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin errs++;
            $display("FAIL fair_cnts: got %0d %0d want 2 2", gnt_cnt0, gnt_cnt1); end
    endtask

    task automatic test_reset_mid_hold;
        @(negedge clk);
        r0v = 1; r0i = I_ADD; r0a = 3; r0b = 2;
        @(posedge clk); #1;
        r0v = 0;
        checks++; if (rsp0_valid !== 1'b1) begin errs++;
            $display("FAIL rmh_pre: got rsp0 %b want 1", rsp0_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp0_valid !== 1'b0 || rsp_result !== 32'd0 || gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0 || busy !== 1'b0) begin errs++;
            $display("FAIL rmh_async: got v%b res %0d cnt %0d/%0d busy %b want all 0",
                     rsp0_valid, rsp_result, gnt_cnt0, gnt_cnt1, busy); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin errs++;
            $display("FAIL rmh_stale: got v%b%b busy %b want 00 0", rsp1_valid, rsp0_valid, busy); end
    endtask

    task automatic test_saturation;
        do_reset();
        s_s1r = 1;
        for (int i = 0; i < 5; i++) begin
            int exp;
            exp = (i + 1 > 3) ? 3 : i + 1;
            @(negedge clk); s_r1v = 1;
            @(posedge clk); #1;
            checks++; if (s_cnt1 !== 2'(exp)) begin errs++;
                $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_cnt1, exp); end
        end
        @(negedge clk); s_r1v = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_cnt1 !== 2'd3 || s_cnt0 !== 2'd0) begin errs++;
            $display("FAIL sat_hold: got %0d %0d want 3 0", s_cnt1, s_cnt0); end
        s_s1r = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_mid_hold();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
